// File: rtl/rr_mux_n.sv
// N-channel round-robin mux with a single registered output slot (valid/ready both sides).
// Optional RR_MUX_N_STATS_EN adds a saturating 16-bit output-transfer counter (xfer_cnt).

module rr_mux_n_lane #(
  parameter int W = 8
) (
  input  logic         gnt,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic         rdy,
  output logic [W-1:0] dmask
);
  assign rdy   = en & gnt;
  assign dmask = gnt ? din : '0;
endmodule

module rr_mux_n #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
`ifdef RR_MUX_N_STATS_EN
  ,
  output logic [15:0]    xfer_cnt
`endif
);
  logic [N-1:0][W-1:0] din;
  logic [N-1:0][W-1:0] dmask;
  logic [N-1:0]        gnt_oh;
  logic [SW-1:0]       ptr;
  logic [SW-1:0]       gnt;
  logic                gnt_vld;
  logic                ld;
  logic                en;
  logic                xfer;
  logic [W-1:0]        mux_data;
  logic [SW:0]         idx;

  assign din = in_data;
  assign ld  = !out_valid || out_ready;
  // rst_n gates the grant so in_ready stays low throughout reset
  assign en  = rst_n && ld && gnt_vld;

  // Descending scan so the last hit is the nearest channel at/after ptr.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (SW+1)'(k);
      if (idx >= (SW+1)'(N)) idx = idx - (SW+1)'(N);
      if (in_valid[idx[SW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt     = idx[SW-1:0];
      end
    end
  end

  assign gnt_oh = gnt_vld ? (N'(1) << gnt) : '0;

  for (genvar i = 0; i < N; i++) begin : g_lane
    rr_mux_n_lane #(.W(W)) u_lane (
      .gnt   (gnt_oh[i]),
      .en    (en),
      .din   (din[i]),
      .rdy   (in_ready[i]),
      .dmask (dmask[i])
    );
  end

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N; i++) mux_data = mux_data | dmask[i];
  end

  assign xfer = |(in_ready & in_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (ld) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= mux_data;
        out_sel   <= gnt;
        ptr       <= (gnt == SW'(N - 1)) ? '0 : gnt + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef RR_MUX_N_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                              xfer_cnt <= '0;
    else if (out_valid && out_ready && xfer_cnt != 16'hFFFF) xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_rr_mux_n.sv
// Directed + scoreboarded random bench for rr_mux_n (N=4 and N=3 instances).
module tb_rr_mux_n;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   in_valid = '0;
  logic [N*W-1:0] in_data  = '0;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_ready = 1'b1;

  logic [2:0]     v3 = '0;
  logic [23:0]    d3 = {8'hC2, 8'hC1, 8'hC0};
  logic [2:0]     r3;
  logic           ov3;
  logic [7:0]     od3;
  logic [1:0]     os3;
  logic           ord3 = 1'b1;

`ifdef RR_MUX_N_STATS_EN
  logic [15:0] xc4, xc3;
`endif

  rr_mux_n #(.N(N), .W(W)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
`ifdef RR_MUX_N_STATS_EN
    , .xfer_cnt(xc4)
`endif
  );

  rr_mux_n #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_data(d3), .in_ready(r3),
    .out_valid(ov3), .out_data(od3), .out_sel(os3), .out_ready(ord3)
`ifdef RR_MUX_N_STATS_EN
    , .xfer_cnt(xc3)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp3[4];
    int mptr;
    int g;
    int idx;
    int exprdy;
    logic mov;
    logic ldm;
    logic [7:0] q[$];
    logic [7:0] w;
    int waits[N];
    logic [5:0] seq[N];

    // reset state with all channels requesting
    in_valid = 4'hF;
    #3;
    chk("rst_ovld", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sel", out_sel, 0);
    chk("rst_rdy", in_ready, 0);
    step;
    rst_n = 1'b1;

    // all valid, full rate rotation
    in_data = {8'h31, 8'h21, 8'h11, 8'h01};
    out_ready = 1'b1;
    #1;
    chk("s1_rdy0", in_ready, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      step;
      chk("s1_vld", out_valid, 1);
      chk("s1_sel", out_sel, i % 4);
      chk("s1_dat", out_data, (i % 4) * 16 + 1);
      chk("s1_rdy", in_ready, 1 << ((i + 1) % 4));
    end
    in_valid = '0;
    step;
    chk("s1_idle_vld", out_valid, 0);
    chk("s1_idle_sel", out_sel, 0);
    chk("s1_idle_dat", out_data, 8'h01);

    // single channel, downstream stall
    in_valid = 4'b0100;
    in_data[2*W +: W] = 8'hA5;
    out_ready = 1'b0;
    #1;
    chk("s2_rdy", in_ready, 4'b0100);
    step;
    chk("s2_vld", out_valid, 1);
    chk("s2_sel", out_sel, 2);
    for (int i = 0; i < 3; i++) begin
      chk("s2_stall_rdy", in_ready, 0);
      chk("s2_stall_dat", out_data, 8'hA5);
      chk("s2_stall_vld", out_valid, 1);
      step;
    end
    out_ready = 1'b1;
    in_valid = '0;
    #1;
    chk("s2_xfer", out_valid & out_ready, 1);
    step;
    chk("s2_after", out_valid, 0);

    // async reset mid-stream; ptr is 3 here
    in_valid = 4'b1010;
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    #1;
    chk("s4_rdy_a", in_ready, 4'b1000);
    step;
    chk("s4_sel_a", out_sel, 3);
    step;
    chk("s4_sel_b", out_sel, 1);
    chk("s4_vld_b", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s4_rst_vld", out_valid, 0);
    chk("s4_rst_rdy", in_ready, 0);
    chk("s4_rst_sel", out_sel, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("s4_rel_rdy", in_ready, 4'b0010);
    step;
    chk("s4_rel_sel", out_sel, 1);
    chk("s4_rel_dat", out_data, 8'h22);
    in_valid = '0;

    // N=3: move ptr to 2, then channels 2 and 0 alternate
    v3 = 3'b010;
    step;
    chk("s3_pre_sel", os3, 1);
    v3 = 3'b101;
    #1;
    chk("s3_rdy", r3, 3'b100);
    exp3 = '{2, 0, 2, 0};
    for (int i = 0; i < 4; i++) begin
      step;
      chk("s3_sel", os3, exp3[i]);
      chk("s3_dat", od3, 8'hC0 + exp3[i]);
      chk("s3_vld", ov3, 1);
    end
    v3 = '0;

    // random traffic against a scoreboard; reset first to sync the model ptr
    rst_n = 1'b0;
    in_valid = '0;
    step;
    rst_n = 1'b1;
`ifdef RR_MUX_N_STATS_EN
    chk("st_rst", xc4, 0);
`endif
    mptr = 0;
    mov = 1'b0;
    for (int i = 0; i < N; i++) begin
      waits[i] = 0;
      seq[i] = '0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < N; i++)
        if (!in_valid[i] && $urandom_range(0, 2) == 0) begin
          in_valid[i] = 1'b1;
          in_data[i*W +: W] = 8'((i << 6) | int'(seq[i]));
          seq[i] = seq[i] + 6'd1;
        end
      out_ready = ($urandom_range(0, 3) != 0);
      #2;
      ldm = !mov || out_ready;
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (g < 0 && in_valid[idx]) g = idx;
      end
      exprdy = (ldm && g >= 0) ? (1 << g) : 0;
      chk("rnd_rdy", in_ready, exprdy);
      chk("rnd_ovld", out_valid, mov);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rnd_dup", 0, 1);
        else begin
          w = q.pop_front();
          chk("rnd_dat", out_data, w);
        end
      end
      if (ldm) mov = (g >= 0);
      if (ldm && g >= 0) begin
        q.push_back(in_data[g*W +: W]);
        for (int i = 0; i < N; i++)
          if (i != g && in_valid[i]) waits[i]++;
        chk("rnd_starve", waits[g] < N, 1);
        waits[g] = 0;
        mptr = (g + 1) % N;
      end
      @(posedge clk);
      #1;
      if (ldm && g >= 0) in_valid[g] = 1'b0;
    end
    in_valid = '0;
    out_ready = 1'b1;
    #2;
    if (out_valid) begin
      if (q.size() == 0) chk("rnd_dup", 0, 1);
      else begin
        w = q.pop_front();
        chk("rnd_dat", out_data, w);
      end
    end
    step;
    chk("rnd_q_empty", q.size(), 0);
    chk("rnd_end_vld", out_valid, 0);

`ifdef RR_MUX_N_STATS_EN
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    chk("st_rst2", xc4, 0);
    in_valid = 4'hF;
    out_ready = 1'b1;
    repeat (65540) step;
    chk("st_sat", xc4, 16'hFFFF);
    in_valid = '0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rr_mux_n.md
RR_MUX_N -- requirements
Module: rr_mux_n

Interface
REQ-001 Parameter N, default 4: number of input channels; legal range 2..16, not restricted to powers of two.
REQ-002 Parameter W, default 8: data width per channel; legal range 1..64.
REQ-003 Parameter SW, default $clog2(N): width of the channel-select output; not overridden by instantiators.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  N  bit i set: channel i offers a word.
REQ-007 in_data  input  N*W  channel i data at bits [i*W +: W].
REQ-008 in_ready  output  N  bit i set: channel i word accepted this cycle; combinational, one-hot or zero.
REQ-009 out_valid  output  1  out_data holds a valid word.
REQ-010 out_data  output  W  registered selected word.
REQ-011 out_sel  output  SW  index of the channel that supplied out_data.
REQ-012 out_ready  input  1  downstream accepts the word on out_valid & out_ready.

Function
REQ-013 Load condition: load = !out_valid | out_ready; no input is accepted while load is 0.
REQ-014 Arbitration SHALL be round-robin: when load is 1, grant g is the first i with in_valid[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-015 in_ready[g] SHALL be 1 only when load is 1 and a grant exists; all other bits are 0.
REQ-016 On a transfer (in_valid[g] & in_ready[g]), the block SHALL register out_data<=word g, out_sel<=g, and out_valid<=1.
REQ-017 Latency SHALL be one cycle from input acceptance to out_valid.
REQ-018 Throughput SHALL be one word per cycle while out_ready=1.
REQ-019 Pointer update: ptr<=(g==N-1)?0:g+1, only on a transfer; it holds otherwise.
REQ-020 When load is 1 with no in_valid, the block SHALL clear out_valid; out_data and out_sel hold their last values.
REQ-021 out_data and out_sel SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 A simultaneous drain and load in the same cycle SHALL replace the word with no bubble.
REQ-023 Starvation bound: a channel holding in_valid SHALL be granted within N transfers.
REQ-024 No word SHALL be dropped or duplicated: each input transfer yields exactly one output transfer.

Reset
REQ-025 While rst_n=0, the block SHALL hold out_valid=0, out_data=0, out_sel=0, ptr=0, and in_ready=0, regardless of clk.
REQ-026 Reset asserted mid-operation SHALL discard any held word; the first grant after release searches from channel 0.

Configuration
REQ-027 Macro RR_MUX_N_STATS_EN, when defined, SHALL add output xfer_cnt (16 bits): a count of output transfers that saturates at 16'hFFFF and resets to 0.
REQ-028 When RR_MUX_N_STATS_EN is not defined, the port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Scenario: N=4, W=8; all in_valid=1 with data i*16+1; out_ready=1 -> out_sel 0,1,2,3,0 on consecutive cycles, out_data 0x01,0x11,0x21,0x31,0x01, and no bubbles.
REQ-030 Scenario: only channel 2 valid with 0xA5; out_ready=0 for 3 cycles -> out_valid=1 with 0xA5 held stable; in_ready=0 during the stall; one transfer results when out_ready rises.
REQ-031 Scenario: N=3 (non-power-of-two); channels 2 and 0 valid, ptr=2 -> grant order 2,0,2,0 with correct wrap from 2 to 0.
REQ-032 Scenario: rst_n pulled low asynchronously mid-stream with out_valid=1 -> out_valid=0 immediately; after release, the first grant is the lowest valid index.
REQ-033 Scenario: random valid and ready over 10000 cycles against a scoreboard -> no loss or duplication, every channel served within N transfers, and in_ready always one-hot or zero.
REQ-034 Scenario: with RR_MUX_N_STATS_EN defined, force 65540 transfers -> xfer_cnt=16'hFFFF; without the macro, the design compiles with no xfer_cnt port.
